// File: rtl/mem_cmd_scheduler.sv
// mem_cmd_scheduler
//
// Multi-channel command scheduler. Each channel (bank) owns a ready FIFO and a
// pending FIFO. Commands are enqueued into a channel's ready FIFO. On request they
// move to the pending FIFO, where each entry is stamped with a free-running cycle
// count. A pending head becomes eligible once it has aged LATENCY cycles. Eligible
// heads are served round-robin through a single valid/ready dequeue port. Once a
// grant is presented it is held until the consumer accepts it.
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-low reset
//   enq_valid_in      command offer
//   enq_ch_in         target channel of the offer
//   enq_data_in       command payload
//   enq_ready_out     target channel's ready FIFO has room
//   transfer_in       per-channel request to move the ready head into pending
//   deq_valid_out     an eligible command is presented
//   deq_ready_in      consumer accepts the presented command
//   deq_ch_out        channel of the presented command (0 when idle)
//   deq_data_out      payload of the presented command (0 when idle)
//   ready_empty_out   per-channel ready FIFO empty flags
//   pending_empty_out per-channel pending FIFO empty flags
//   ready_full_out    per-channel ready FIFO full flags
//   pending_full_out  per-channel pending FIFO full flags
module mem_cmd_scheduler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned QUEUE_SIZE = 16,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              enq_valid_in,
    input  logic [CH_W-1:0]   enq_ch_in,
    input  logic [DATA_W-1:0] enq_data_in,
    output logic              enq_ready_out,
    input  logic [NUM_CH-1:0] transfer_in,
    output logic              deq_valid_out,
    input  logic              deq_ready_in,
    output logic [CH_W-1:0]   deq_ch_out,
    output logic [DATA_W-1:0] deq_data_out,
    output logic [NUM_CH-1:0] ready_empty_out,
    output logic [NUM_CH-1:0] pending_empty_out,
    output logic [NUM_CH-1:0] ready_full_out,
    output logic [NUM_CH-1:0] pending_full_out
);

    localparam int unsigned      PTR_W   = $clog2(QUEUE_SIZE);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [CNT_W-1:0] LAT     = CNT_W'(LATENCY);

    typedef enum logic [0:0] {
        StIdle,
        StHold
    } lock_state_e;

    logic [NUM_CH-1:0] rdy_empty;
    logic [NUM_CH-1:0] rdy_full;
    logic [NUM_CH-1:0] pnd_empty;
    logic [NUM_CH-1:0] pnd_full;
    logic [NUM_CH-1:0] enq_we;
    logic [NUM_CH-1:0] xfer;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pop;
    logic [DATA_W-1:0] pnd_head [NUM_CH];

    logic [CNT_W-1:0]  cnt_q;
    lock_state_e       state_q, state_d;
    logic [CH_W-1:0]   gnt_q, gnt_d;
    logic [CH_W-1:0]   rr_q, rr_d;

    logic              enq_ch_ok;
    logic              any_elig;
    logic [CH_W-1:0]   sel;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   next_rr;
    logic              handshake;

    // Out-of-range channel numbers only exist when NUM_CH is not a power of two.
    if (NUM_CH == (1 << CH_W)) begin : g_ch_full_range
        assign enq_ch_ok = 1'b1;
    end else begin : g_ch_part_range
        assign enq_ch_ok = (32'(enq_ch_in) < NUM_CH);
    end

    assign enq_ready_out = enq_ch_ok && !rdy_full[enq_ch_in];

    // ------------------------------------------------------------------------
    // Per-channel ready/pending FIFOs
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [PTR_W:0]    rq_wp_q, rq_rp_q;
        logic [PTR_W:0]    pq_wp_q, pq_rp_q;
        logic [DATA_W-1:0] rq_mem_q   [QUEUE_SIZE];
        logic [DATA_W-1:0] pq_mem_q   [QUEUE_SIZE];
        logic [CNT_W-1:0]  pq_stamp_q [QUEUE_SIZE];
        logic [CNT_W-1:0]  age;
        logic              ripe_q;

        // Extra pointer MSB distinguishes full from empty.
        assign rdy_empty[c] = (rq_wp_q == rq_rp_q);
        assign rdy_full[c]  = (rq_wp_q[PTR_W] != rq_rp_q[PTR_W]) &&
                              (rq_wp_q[PTR_W-1:0] == rq_rp_q[PTR_W-1:0]);
        assign pnd_empty[c] = (pq_wp_q == pq_rp_q);
        assign pnd_full[c]  = (pq_wp_q[PTR_W] != pq_rp_q[PTR_W]) &&
                              (pq_wp_q[PTR_W-1:0] == pq_rp_q[PTR_W-1:0]);

        assign enq_we[c] = enq_valid_in && enq_ready_out && (enq_ch_in == CH_W'(c));
        // Full is taken from the registered pointers, i.e. before any same-cycle pop.
        assign xfer[c]   = transfer_in[c] && !rdy_empty[c] && !pnd_full[c];

        // Modular difference keeps the age correct across counter wrap; the sticky
        // ripe flag covers heads that wait long enough for the age itself to wrap.
        assign age         = cnt_q - pq_stamp_q[pq_rp_q[PTR_W-1:0]];
        assign eligible[c] = !pnd_empty[c] && (ripe_q || (age >= LAT));
        assign pnd_head[c] = pq_mem_q[pq_rp_q[PTR_W-1:0]];

        always_ff @(posedge clk_in or negedge rst_in) begin
            if (!rst_in) begin
                rq_wp_q    <= '0;
                rq_rp_q    <= '0;
                pq_wp_q    <= '0;
                pq_rp_q    <= '0;
                ripe_q     <= 1'b0;
                pq_stamp_q <= '{default: '0};
            end else begin
                if (enq_we[c]) begin
                    rq_wp_q <= rq_wp_q + PTR_ONE;
                end
                if (xfer[c]) begin
                    rq_rp_q                          <= rq_rp_q + PTR_ONE;
                    pq_wp_q                          <= pq_wp_q + PTR_ONE;
                    pq_stamp_q[pq_wp_q[PTR_W-1:0]]   <= cnt_q;
                end
                if (pop[c]) begin
                    pq_rp_q <= pq_rp_q + PTR_ONE;
                    ripe_q  <= 1'b0;
                end else begin
                    ripe_q  <= eligible[c];
                end
            end
        end

        // Payload storage needs no reset: the pointers define what is valid.
        always_ff @(posedge clk_in) begin
            if (enq_we[c]) begin
                rq_mem_q[rq_wp_q[PTR_W-1:0]] <= enq_data_in;
            end
            if (xfer[c]) begin
                pq_mem_q[pq_wp_q[PTR_W-1:0]] <= rq_mem_q[rq_rp_q[PTR_W-1:0]];
            end
        end
    end

    assign ready_empty_out   = rdy_empty;
    assign pending_empty_out = pnd_empty;
    assign ready_full_out    = rdy_full;
    assign pending_full_out  = pnd_full;

    // ------------------------------------------------------------------------
    // Round-robin arbiter: first eligible channel at or after rr_q
    // ------------------------------------------------------------------------
    always_comb begin
        int unsigned     idx;
        logic [CH_W-1:0] cand;
        idx      = 0;
        cand     = '0;
        sel      = '0;
        any_elig = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            cand = CH_W'(idx);
            if (!any_elig && eligible[cand]) begin
                any_elig = 1'b1;
                sel      = cand;
            end
        end
    end

    // A presented grant is locked so the outputs cannot move under the consumer.
    assign gnt_ch        = (state_q == StHold) ? gnt_q : sel;
    assign deq_valid_out = (state_q == StHold) ? eligible[gnt_q] : any_elig;
    assign handshake     = deq_valid_out && deq_ready_in;
    assign next_rr       = (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);

    assign deq_ch_out    = deq_valid_out ? gnt_ch : '0;
    assign deq_data_out  = deq_valid_out ? pnd_head[gnt_ch] : '0;

    always_comb begin
        pop = '0;
        if (handshake) begin
            pop[gnt_ch] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        case (state_q)
            StIdle: begin
                if (any_elig) begin
                    if (deq_ready_in) begin
                        rr_d = next_rr;
                    end else begin
                        state_d = StHold;
                        gnt_d   = sel;
                    end
                end
            end
            StHold: begin
                if (handshake) begin
                    state_d = StIdle;
                    rr_d    = next_rr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_mem_cmd_scheduler.sv
// Directed bench for mem_cmd_scheduler: 4 channels, 16-deep FIFOs, LATENCY 4 and a
// 5-bit counter so that counter wrap is reachable in a few dozen cycles. The counter
// is zeroed by reset, so its value is known from the number of clocks since release.
module tb_mem_cmd_scheduler;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned QUEUE_SIZE = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned LATENCY    = 4;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CNT_MOD    = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enq_valid;
    logic [1:0]        enq_ch;
    logic [DATA_W-1:0] enq_data;
    logic              enq_ready;
    logic [3:0]        transfer;
    logic              deq_valid;
    logic              deq_ready;
    logic [1:0]        deq_ch;
    logic [DATA_W-1:0] deq_data;
    logic [3:0]        ready_empty;
    logic [3:0]        pending_empty;
    logic [3:0]        ready_full;
    logic [3:0]        pending_full;

    int n_vec     = 0;
    int n_err     = 0;
    int model_cnt = 0;
    int k;

    always #5 clk = ~clk;

    mem_cmd_scheduler #(
        .NUM_CH     (NUM_CH),
        .QUEUE_SIZE (QUEUE_SIZE),
        .DATA_W     (DATA_W),
        .LATENCY    (LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst_n),
        .enq_valid_in      (enq_valid),
        .enq_ch_in         (enq_ch),
        .enq_data_in       (enq_data),
        .enq_ready_out     (enq_ready),
        .transfer_in       (transfer),
        .deq_valid_out     (deq_valid),
        .deq_ready_in      (deq_ready),
        .deq_ch_out        (deq_ch),
        .deq_data_out      (deq_data),
        .ready_empty_out   (ready_empty),
        .pending_empty_out (pending_empty),
        .ready_full_out    (ready_full),
        .pending_full_out  (pending_full)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst_n) model_cnt = (model_cnt + 1) % CNT_MOD;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},   32'(deq_valid), 0);
        chk({tag, "_ch"},      32'(deq_ch), 0);
        chk({tag, "_data"},    32'(deq_data), 0);
        chk({tag, "_rempty"},  32'(ready_empty), 32'hF);
        chk({tag, "_pempty"},  32'(pending_empty), 32'hF);
        chk({tag, "_rfull"},   32'(ready_full), 0);
        chk({tag, "_pfull"},   32'(pending_full), 0);
        chk({tag, "_enq_rdy"}, 32'(enq_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        enq_valid = 1'b0;
        enq_ch    = 2'd0;
        enq_data  = '0;
        transfer  = 4'b0000;
        deq_ready = 1'b0;

        #3;
        chk_reset_vals("rst0");
        tick();
        tick();
        rst_n     = 1'b1;
        model_cnt = 0;

        // ---- first-command latency: enqueue t0, transfer t1, eligible t5 ----
        enq_valid = 1'b1; enq_ch = 2'd1; enq_data = 16'h00A5; #1;
        chk("a_enq_ready", 32'(enq_ready), 1);
        tick();
        enq_valid = 1'b0; transfer = 4'b0010; #1;
        chk("a_t1_rempty", 32'(ready_empty), 32'hD);
        chk("a_t1_valid", 32'(deq_valid), 0);
        tick();
        transfer = 4'b0000; #1;
        chk("a_t2_pempty", 32'(pending_empty), 32'hD);
        chk("a_t2_rempty", 32'(ready_empty), 32'hF);
        chk("a_t2_valid", 32'(deq_valid), 0);
        tick(); #1;
        chk("a_t3_valid", 32'(deq_valid), 0);
        tick(); #1;
        chk("a_t4_valid", 32'(deq_valid), 0);
        tick(); #1;
        chk("a_t5_valid", 32'(deq_valid), 1);
        chk("a_t5_ch", 32'(deq_ch), 1);
        chk("a_t5_data", 32'(deq_data), 32'h00A5);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0; #1;
        chk("a_t6_valid", 32'(deq_valid), 0);
        chk("a_t6_data", 32'(deq_data), 0);
        chk("a_t6_pempty", 32'(pending_empty), 32'hF);

        // ---- fill ch0, overflow is dropped, ch2 still accepts ----
        enq_valid = 1'b1; enq_ch = 2'd0;
        for (int i = 0; i < 16; i++) begin
            enq_data = 16'h0100 + 16'(i); #1;
            chk("b_fill_ready", 32'(enq_ready), 1);
            tick();
        end
        enq_data = 16'hDEAD; #1;
        chk("b_full_flag", 32'(ready_full), 32'h1);
        chk("b_full_enq_ready", 32'(enq_ready), 0);
        tick();
        enq_ch = 2'd2; enq_data = 16'h0022; #1;
        chk("b_after_drop_full", 32'(ready_full), 32'h1);
        chk("b_ch2_enq_ready", 32'(enq_ready), 1);
        tick();
        enq_valid = 1'b0; #1;
        chk("b_rempty", 32'(ready_empty), 32'hA);
        // Drain ch0 through pending, with transfer and pop overlapping.
        transfer = 4'b0001; deq_ready = 1'b1; k = 0; #1;
        for (int c = 0; c < 40 && k < 16; c++) begin
            if (deq_valid) begin
                chk("b_drain_ch", 32'(deq_ch), 0);
                chk("b_drain_data", 32'(deq_data), 32'h0100 + k);
                k++;
            end
            tick(); #1;
        end
        transfer = 4'b0000; deq_ready = 1'b0; #1;
        chk("b_drain_count", k, 16);
        chk("b_drain_rempty", 32'(ready_empty), 32'hB);
        chk("b_drain_pempty", 32'(pending_empty), 32'hF);

        // ---- same-cycle enqueue and transfer on ch3; its grant moves rr to 0 ----
        enq_valid = 1'b1; enq_ch = 2'd3; enq_data = 16'h0030; #1;
        tick();
        enq_data = 16'h0031; transfer = 4'b1000; #1;
        chk("r21_enq_ready", 32'(enq_ready), 1);
        tick();
        enq_valid = 1'b0; transfer = 4'b0000; #1;
        chk("r21_rempty", 32'(ready_empty), 32'h3);
        chk("r21_pempty", 32'(pending_empty), 32'h7);
        tick(); #1;
        chk("r21_early1", 32'(deq_valid), 0);
        tick(); #1;
        chk("r21_early2", 32'(deq_valid), 0);
        tick(); #1;
        chk("r21_valid", 32'(deq_valid), 1);
        chk("r21_ch", 32'(deq_ch), 3);
        chk("r21_data", 32'(deq_data), 32'h0030);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0; #1;

        // ---- round robin: ch0, ch2, ch3 ripe together, rr = 0 ----
        enq_valid = 1'b1; enq_ch = 2'd0; enq_data = 16'h00C0; #1;
        tick();
        enq_valid = 1'b0; transfer = 4'b1101; deq_ready = 1'b1; #1;
        tick();
        transfer = 4'b0000; #1;
        chk("c_early2", 32'(deq_valid), 0);
        tick(); #1;
        chk("c_early3", 32'(deq_valid), 0);
        tick(); #1;
        chk("c_early4", 32'(deq_valid), 0);
        tick(); #1;
        chk("c_g1_ch", 32'(deq_ch), 0);
        chk("c_g1_data", 32'(deq_data), 32'h00C0);
        tick(); #1;
        chk("c_g2_ch", 32'(deq_ch), 2);
        chk("c_g2_data", 32'(deq_data), 32'h0022);
        tick(); #1;
        chk("c_g3_ch", 32'(deq_ch), 3);
        chk("c_g3_data", 32'(deq_data), 32'h0031);
        chk("c_g3_valid", 32'(deq_valid), 1);
        tick(); #1;
        chk("c_done_valid", 32'(deq_valid), 0);
        chk("c_rr_ptr", 32'(dut.rr_q), 0);
        deq_ready = 1'b0;

        // ---- grant lock: ch3 held under backpressure while ch0 ripens ----
        enq_valid = 1'b1; enq_ch = 2'd3; enq_data = 16'h00D3; #1;
        tick();
        enq_ch = 2'd0; enq_data = 16'h00D0; transfer = 4'b1000; #1;
        tick();
        enq_valid = 1'b0; transfer = 4'b0001; #1;
        tick();
        transfer = 4'b0000; #1;
        chk("d_early3", 32'(deq_valid), 0);
        tick(); #1;
        chk("d_early4", 32'(deq_valid), 0);
        tick(); #1;
        for (int i = 0; i < 5; i++) begin
            chk("d_hold_valid", 32'(deq_valid), 1);
            chk("d_hold_ch", 32'(deq_ch), 3);
            chk("d_hold_data", 32'(deq_data), 32'h00D3);
            tick(); #1;
        end
        deq_ready = 1'b1; #1;
        chk("d_acc3_ch", 32'(deq_ch), 3);
        chk("d_acc3_data", 32'(deq_data), 32'h00D3);
        tick(); #1;
        chk("d_acc0_valid", 32'(deq_valid), 1);
        chk("d_acc0_ch", 32'(deq_ch), 0);
        chk("d_acc0_data", 32'(deq_data), 32'h00D0);
        tick();
        deq_ready = 1'b0; #1;
        chk("d_done_valid", 32'(deq_valid), 0);

        // ---- counter wrap: stamp taken at count 30 (2^5 - 2) ----
        for (int c = 0; c < 40 && model_cnt != 29; c++) tick();
        enq_valid = 1'b1; enq_ch = 2'd1; enq_data = 16'h00E1; #1;
        tick();
        enq_valid = 1'b0; transfer = 4'b0010; #1;
        tick();
        transfer = 4'b0000; #1;
        chk("e_early1", 32'(deq_valid), 0);
        tick(); #1;
        chk("e_early2", 32'(deq_valid), 0);
        tick(); #1;
        chk("e_early3", 32'(deq_valid), 0);
        tick(); #1;
        chk("e_wrap_valid", 32'(deq_valid), 1);
        chk("e_wrap_ch", 32'(deq_ch), 1);
        chk("e_wrap_data", 32'(deq_data), 32'h00E1);
        // Hold past a full counter period, when the raw age has wrapped below 4.
        for (int i = 0; i < 34; i++) begin
            tick(); #1;
            chk("e_hold_valid", 32'(deq_valid), 1);
        end
        chk("e_hold_data", 32'(deq_data), 32'h00E1);
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0; #1;
        chk("e_done_valid", 32'(deq_valid), 0);

        // ---- reset mid-stream with three pending entries ----
        enq_valid = 1'b1; enq_ch = 2'd0; enq_data = 16'h00F0; #1;
        tick();
        enq_ch = 2'd1; enq_data = 16'h00F1; #1;
        tick();
        enq_ch = 2'd2; enq_data = 16'h00F2; #1;
        tick();
        enq_valid = 1'b0; transfer = 4'b0111; #1;
        tick();
        transfer = 4'b0000; #1;
        chk("f_pempty", 32'(pending_empty), 32'h8);
        tick(); tick(); tick(); #1;
        chk("f_pre_valid", 32'(deq_valid), 1);
        chk("f_pre_ch", 32'(deq_ch), 2);
        chk("f_pre_data", 32'(deq_data), 32'h00F2);
        #2;
        rst_n = 1'b0; #1;
        chk_reset_vals("f_rst");
        tick();
        tick();
        rst_n     = 1'b1;
        model_cnt = 0;
        deq_ready = 1'b1; transfer = 4'b1111; #1;
        for (int i = 0; i < 10; i++) begin
            chk("f_post_valid", 32'(deq_valid), 0);
            chk("f_post_pempty", 32'(pending_empty), 32'hF);
            tick(); #1;
        end
        chk("f_post_data", 32'(deq_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_cmd_scheduler.md
MEM_CMD_SCHEDULER -- requirements
Module: mem_cmd_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, giving the number of independent command channels (banks), >=1.
REQ-002 The module SHALL have parameter QUEUE_SIZE, default 16, giving per-channel ready and pending FIFO depth, a power of 2 and >=2.
REQ-003 The module SHALL have parameter DATA_W, default 64, giving the command payload width.
REQ-004 The module SHALL have parameter LATENCY, default 4, giving the minimum cycles between transfer into pending and eligibility.
REQ-005 The module SHALL have parameter CNT_W, default 32, giving the internal cycle-counter and timestamp width.
REQ-006 The module SHALL have port clk_in, input, 1 bit: the single clock, rising-edge.
REQ-007 The module SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port enq_valid_in, input, 1 bit: the command offer.
REQ-009 The module SHALL have port enq_ch_in, input, CH_W=max(1,$clog2(NUM_CH)) bits: the target channel.
REQ-010 The module SHALL have port enq_data_in, input, DATA_W bits: the command payload.
REQ-011 The module SHALL have port enq_ready_out, output, 1 bit: the target channel's ready FIFO can accept.
REQ-012 The module SHALL have port transfer_in, input, NUM_CH bits: a per-channel request to move the ready head into pending.
REQ-013 The module SHALL have port deq_valid_out, output, 1 bit: an eligible command is presented.
REQ-014 The module SHALL have port deq_ready_in, input, 1 bit: the consumer accepts the presented command.
REQ-015 The module SHALL have port deq_ch_out, output, CH_W bits: the channel of the presented command.
REQ-016 The module SHALL have port deq_data_out, output, DATA_W bits: the presented payload.
REQ-017 The module SHALL have ports ready_empty_out and pending_empty_out, output, NUM_CH bits each: per-channel empty flags.
REQ-018 The module SHALL have ports ready_full_out and pending_full_out, output, NUM_CH bits each: per-channel full flags.

Function
REQ-019 Enqueue: enq_ready_out SHALL equal !ready_full[enq_ch_in]; a command SHALL be written when enq_valid_in & enq_ready_out; an enqueue to a full FIFO SHALL be dropped with no state change.
REQ-020 Transfer: when transfer_in[c] & !ready_empty[c] & !pending_full[c], the ready head of channel c SHALL move to pending tail and be stamped with the current cycle count; otherwise transfer_in[c] SHALL be ignored.
REQ-021 An entry enqueued in cycle t SHALL NOT be transferable before cycle t+1; same-cycle enqueue and transfer on one channel SHALL both take effect, and occupancy SHALL be unchanged.
REQ-022 The cycle counter SHALL be free-running, CNT_W bits, and wrap modulo 2^CNT_W.
REQ-023 The pending head of channel c SHALL become eligible when (count - stamp) mod 2^CNT_W >= LATENCY; a per-channel sticky ripe flag SHALL hold eligibility until that head is dequeued, immune to counter wrap.
REQ-024 With LATENCY=0, an entry transferred in cycle t SHALL be eligible in cycle t+1.
REQ-025 Arbitration SHALL be round-robin among eligible channels, starting from the pointer rr_ptr.
REQ-026 On handshake (deq_valid_out & deq_ready_in), the granted pending head SHALL be popped and rr_ptr SHALL be set to the granted channel + 1 mod NUM_CH.
REQ-027 Once deq_valid_out is asserted, the grant SHALL be locked, and deq_ch_out/deq_data_out SHALL stay stable until handshake, even if other channels become eligible.
REQ-028 deq_data_out and deq_ch_out SHALL be 0 when deq_valid_out=0.
REQ-029 Same-cycle pop and transfer on one pending FIFO SHALL both take effect; pending_full SHALL be evaluated before the pop.
REQ-030 Pointer wrap: FIFO read and write pointers SHALL wrap at QUEUE_SIZE; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-031 Asserting rst_in low SHALL, asynchronously, empty all FIFOs, clear stamps and ripe flags, zero the counter, rr_ptr and grant lock, and drive deq_valid_out=0, deq_ch_out=0, deq_data_out=0, ready_empty_out/pending_empty_out all 1s, full flags 0, enq_ready_out=1.
REQ-032 A reset mid-operation SHALL discard all in-flight commands; no command SHALL be presented until re-enqueued after rst_in returns high.

Verification
REQ-033 The bench SHALL cover: LATENCY=4; enqueue ch1 data 0xA5 at t0, transfer at t1 -> deq_valid_out=1, deq_ch_out=1, deq_data_out=0xA5 first at t5, not earlier.
REQ-034 The bench SHALL cover: QUEUE_SIZE=16 entries to ch0 -> ready_full_out[0]=1, enq_ready_out=0 for ch0; the 17th enqueue is dropped; ch2 still accepts.
REQ-035 The bench SHALL cover: ch0, ch2 and ch3 eligible with rr_ptr=0 and deq_ready_in held 1 -> grant order 0,2,3, and rr_ptr=0 afterwards.
REQ-036 The bench SHALL cover: deq_ready_in=0 for 5 cycles with ch3 granted while ch0 becomes eligible -> outputs stay ch3 and payload unchanged; ch3 is accepted, then ch0.
REQ-037 The bench SHALL cover: counter preloaded near 2^CNT_W-2, LATENCY=4, transfer -> eligible exactly 4 cycles later across wrap and still eligible 2^CNT_W cycles later.
REQ-038 The bench SHALL cover: rst_in low mid-stream with 3 pending entries -> outputs reach reset values immediately; no stale command appears after release.
